// File: rtl/sram_axi_responder.sv
// Bridges the core's instruction/data SRAM-style ports onto single-beat AXI
// transactions, one outstanding at a time, data port first.
module sram_axi_responder #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  // core instruction port
  input  logic        inst_sram_en,
  input  logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_rdata,
  // core data port
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq,
  // AXI read address / data
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  // AXI write address / data / response
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {
    IDLE,
    D_RD_A,
    D_RD_D,
    D_WR,
    D_WB,
    I_RD_A,
    I_RD_D,
    DONE
  } state_t;

  state_t      state_reg, state_next;
  logic        inst_pend_reg, inst_pend_next;
  logic [31:0] inst_addr_reg, inst_addr_next;
  logic [31:0] data_addr_reg, data_addr_next;
  logic [31:0] data_wdata_reg, data_wdata_next;
  logic [3:0]  data_wen_reg, data_wen_next;
  logic        aw_done_reg, aw_done_next;
  logic        w_done_reg, w_done_next;
  logic [31:0] inst_rdata_reg, inst_rdata_next;
  logic [31:0] data_rdata_reg, data_rdata_next;

  logic aw_hs;
  logic w_hs;
  logic aw_fin;
  logic w_fin;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      inst_pend_reg  <= 1'b0;
      inst_addr_reg  <= 32'd0;
      data_addr_reg  <= 32'd0;
      data_wdata_reg <= 32'd0;
      data_wen_reg   <= 4'd0;
      aw_done_reg    <= 1'b0;
      w_done_reg     <= 1'b0;
      inst_rdata_reg <= 32'd0;
      data_rdata_reg <= 32'd0;
    end else begin
      state_reg      <= state_next;
      inst_pend_reg  <= inst_pend_next;
      inst_addr_reg  <= inst_addr_next;
      data_addr_reg  <= data_addr_next;
      data_wdata_reg <= data_wdata_next;
      data_wen_reg   <= data_wen_next;
      aw_done_reg    <= aw_done_next;
      w_done_reg     <= w_done_next;
      inst_rdata_reg <= inst_rdata_next;
      data_rdata_reg <= data_rdata_next;
    end
  end

  // Write-channel handshakes are tracked independently so AW and W may
  // complete in either order or together.
  assign aw_hs  = awvalid & awready;
  assign w_hs   = wvalid & wready;
  assign aw_fin = aw_done_reg | aw_hs;
  assign w_fin  = w_done_reg | w_hs;

  always_comb begin
    state_next      = state_reg;
    inst_pend_next  = inst_pend_reg;
    inst_addr_next  = inst_addr_reg;
    data_addr_next  = data_addr_reg;
    data_wdata_next = data_wdata_reg;
    data_wen_next   = data_wen_reg;
    aw_done_next    = aw_done_reg;
    w_done_next     = w_done_reg;
    inst_rdata_next = inst_rdata_reg;
    data_rdata_next = data_rdata_reg;

    case (state_reg)
      IDLE: begin
        aw_done_next = 1'b0;
        w_done_next  = 1'b0;
        if (data_sram_en) begin
          data_addr_next  = data_sram_addr;
          data_wdata_next = data_sram_wdata;
          data_wen_next   = data_sram_wen;
          inst_pend_next  = inst_sram_en;
          inst_addr_next  = inst_sram_addr;
          state_next      = (data_sram_wen == 4'd0) ? D_RD_A : D_WR;
        end else if (inst_sram_en) begin
          inst_pend_next = 1'b0;
          inst_addr_next = inst_sram_addr;
          state_next     = I_RD_A;
        end
      end
      D_RD_A: begin
        if (arready) state_next = D_RD_D;
      end
      D_RD_D: begin
        if (rvalid) begin
          data_rdata_next = rdata;
          state_next      = inst_pend_reg ? I_RD_A : DONE;
          inst_pend_next  = 1'b0;
        end
      end
      D_WR: begin
        aw_done_next = aw_fin;
        w_done_next  = w_fin;
        if (aw_fin && w_fin) begin
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
          state_next   = D_WB;
        end
      end
      D_WB: begin
        if (bvalid) begin
          state_next     = inst_pend_reg ? I_RD_A : DONE;
          inst_pend_next = 1'b0;
        end
      end
      I_RD_A: begin
        if (arready) state_next = I_RD_D;
      end
      I_RD_D: begin
        if (rvalid) begin
          inst_rdata_next = rdata;
          state_next      = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // All AXI valid/ready outputs decode from registered state only.
  assign arvalid = (state_reg == D_RD_A) || (state_reg == I_RD_A);
  assign arid    = (state_reg == I_RD_A) ? INST_ID : DATA_ID;
  assign araddr  = (state_reg == I_RD_A) ? inst_addr_reg : data_addr_reg;
  assign rready  = (state_reg == D_RD_D) || (state_reg == I_RD_D);

  assign awvalid = (state_reg == D_WR) && !aw_done_reg;
  assign awid    = DATA_ID;
  assign awaddr  = data_addr_reg;
  assign wvalid  = (state_reg == D_WR) && !w_done_reg;
  assign wdata   = data_wdata_reg;
  assign wstrb   = data_wen_reg;
  assign bready  = (state_reg == D_WB);

  assign inst_sram_rdata = inst_rdata_reg;
  assign data_sram_rdata = data_rdata_reg;

  // DONE is the only cycle in which a presented request is released.
  assign stallreq = (inst_sram_en | data_sram_en) & (state_reg != DONE);

endmodule

// File: tb/tb_sram_axi_responder.sv
// Directed bench for sram_axi_responder: a delay-configurable AXI slave, a
// stimulus process pushing expectations, and a monitor process that checks them.
module tb_sram_axi_responder;

  logic        clk;
  logic        rst;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        stallreq;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  sram_axi_responder #(.INST_ID(4'd0), .DATA_ID(4'd1)) dut (
    .clk(clk), .rst(rst),
    .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata), .stallreq(stallreq),
    .arid(arid), .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- AXI slave model ----------------
  int ar_delay, r_delay, aw_delay, w_delay, b_delay;
  int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
  logic        r_pend, b_pend, aw_seen, w_seen;
  logic [31:0] r_data;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'hBFC00000: return 32'h3C011234;
      32'hBFC00004: return 32'h22222222;
      32'h80002000: return 32'h11111111;
      32'h80003000: return 32'hCAFEF00D;
      default:      return 32'hBAD0BAD0;
    endcase
  endfunction

  assign arready = arvalid && (ar_cnt >= ar_delay);
  assign awready = awvalid && (aw_cnt >= aw_delay);
  assign wready  = wvalid && (w_cnt >= w_delay);
  assign rvalid  = r_pend && (r_cnt >= r_delay);
  assign bvalid  = b_pend && (b_cnt >= b_delay);
  assign rdata   = r_data;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ar_cnt <= 0; r_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
      r_pend <= 1'b0; b_pend <= 1'b0; aw_seen <= 1'b0; w_seen <= 1'b0;
      r_data <= 32'd0;
    end else begin
      ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
      if (arvalid && arready) begin
        r_pend <= 1'b1;
        r_cnt  <= 0;
        r_data <= mem_rd(araddr);
      end else if (rvalid && rready) begin
        r_pend <= 1'b0;
      end else if (r_pend && !rvalid) begin
        r_cnt <= r_cnt + 1;
      end
      if ((aw_seen || (awvalid && awready)) && (w_seen || (wvalid && wready)) && !b_pend) begin
        b_pend  <= 1'b1;
        b_cnt   <= 0;
        aw_seen <= 1'b0;
        w_seen  <= 1'b0;
      end else begin
        aw_seen <= aw_seen || (awvalid && awready);
        w_seen  <= w_seen || (wvalid && wready);
        if (bvalid && bready) b_pend <= 1'b0;
        else if (b_pend && !bvalid) b_cnt <= b_cnt + 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {logic [3:0] id; logic [31:0] addr;} ar_t;
  typedef struct packed {logic [31:0] data; logic [3:0] strb;} w_t;
  typedef struct packed {logic [31:0] inst; logic [31:0] data; logic [7:0] lat;} done_t;

  ar_t   exp_ar[$];
  ar_t   exp_aw[$];
  w_t    exp_w[$];
  done_t exp_done[$];

  int   checks;
  int   failures;
  int   done_count;
  int   busy_cnt;
  logic end_req, end_ack;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  initial begin
    ar_t a; w_t w; done_t d;
    checks = 0; failures = 0; done_count = 0; busy_cnt = 0; end_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("rst_valids", {27'd0, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
        check("rst_inst_rdata", inst_sram_rdata, 32'd0);
        check("rst_data_rdata", data_sram_rdata, 32'd0);
        exp_ar.delete(); exp_aw.delete(); exp_w.delete(); exp_done.delete();
        busy_cnt = 0;
      end else begin
        if (arvalid && arready) begin
          checks++;
          if (exp_ar.size() == 0) begin
            failures++;
            $display("FAIL ar_unexpected actual=id %h addr %h required=none", arid, araddr);
          end else begin
            a = exp_ar.pop_front();
            $display("AR   id=%h addr=%h", arid, araddr);
            check("ar_id", {28'd0, arid}, {28'd0, a.id});
            check("ar_addr", araddr, a.addr);
            check("ar_aw_exclusive", {31'd0, awvalid}, 32'd0);
          end
        end
        if (awvalid && awready) begin
          checks++;
          if (exp_aw.size() == 0) begin
            failures++;
            $display("FAIL aw_unexpected actual=addr %h required=none", awaddr);
          end else begin
            a = exp_aw.pop_front();
            $display("AW   id=%h addr=%h", awid, awaddr);
            check("aw_id", {28'd0, awid}, {28'd0, a.id});
            check("aw_addr", awaddr, a.addr);
          end
        end
        if (wvalid && wready) begin
          checks++;
          if (exp_w.size() == 0) begin
            failures++;
            $display("FAIL w_unexpected actual=data %h required=none", wdata);
          end else begin
            w = exp_w.pop_front();
            $display("W    data=%h strb=%b", wdata, wstrb);
            check("w_data", wdata, w.data);
            check("w_strb", {28'd0, wstrb}, {28'd0, w.strb});
          end
        end
        if (inst_sram_en || data_sram_en) begin
          if (stallreq) begin
            busy_cnt++;
          end else begin
            checks++;
            if (exp_done.size() == 0) begin
              failures++;
              $display("FAIL done_unexpected actual=stallreq low required=none");
            end else begin
              d = exp_done.pop_front();
              $display("DONE inst=%h data=%h cycles=%0d", inst_sram_rdata, data_sram_rdata, busy_cnt + 1);
              check("done_inst_rdata", inst_sram_rdata, d.inst);
              check("done_data_rdata", data_sram_rdata, d.data);
              if (d.lat != 8'd0) check("done_latency", busy_cnt + 1, {24'd0, d.lat});
            end
            busy_cnt = 0;
            done_count++;
          end
        end
        if (end_req && !end_ack) begin
          checks++;
          if (exp_ar.size() + exp_aw.size() + exp_w.size() + exp_done.size() != 0) begin
            failures++;
            $display("FAIL leftover_expectations actual=%0d required=0",
                     exp_ar.size() + exp_aw.size() + exp_w.size() + exp_done.size());
          end
          end_ack = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_delays(input int ar, input int r, input int aw, input int wd, input int b);
    ar_delay = ar; r_delay = r; aw_delay = aw; w_delay = wd; b_delay = b;
  endtask

  task automatic push_ar(input logic [3:0] id, input logic [31:0] addr);
    ar_t a;
    a.id = id; a.addr = addr;
    exp_ar.push_back(a);
  endtask

  task automatic push_aw(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    ar_t a; w_t w;
    a.id = 4'd1; a.addr = addr;
    w.data = data; w.strb = strb;
    exp_aw.push_back(a);
    exp_w.push_back(w);
  endtask

  task automatic push_done(input logic [31:0] inst, input logic [31:0] data, input logic [7:0] lat);
    done_t d;
    d.inst = inst; d.data = data; d.lat = lat;
    exp_done.push_back(d);
  endtask

  // Called at posedge+1; returns at posedge+1 after the edge that ends DONE.
  task automatic do_req(input logic ien, input logic [31:0] ia, input logic den,
                        input logic [3:0] wen, input logic [31:0] da, input logic [31:0] wd);
    int tgt;
    tgt = done_count + 1;
    inst_sram_en = ien; inst_sram_addr = ia;
    data_sram_en = den; data_sram_wen = wen; data_sram_addr = da; data_sram_wdata = wd;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #2;
      if (done_count >= tgt) break;
    end
    if (done_count < tgt) begin
      $display("FAIL request_timeout actual=no completion required=completion within 300 cycles");
      $fatal(1, "request timeout");
    end
    @(posedge clk); #1;
    inst_sram_en = 1'b0; data_sram_en = 1'b0; data_sram_wen = 4'd0;
  endtask

  initial begin
    rst = 1'b0; end_req = 1'b0;
    inst_sram_en = 1'b0; inst_sram_addr = 32'd0;
    data_sram_en = 1'b0; data_sram_wen = 4'd0; data_sram_addr = 32'd0; data_sram_wdata = 32'd0;
    set_delays(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // fetch: IDLE 1 + AR 3 + R 4 stalled cycles, then DONE
    set_delays(2, 3, 0, 0, 0);
    push_ar(4'd0, 32'hBFC00000);
    push_done(32'h3C011234, 32'h0, 8'd9);
    do_req(1'b1, 32'hBFC00000, 1'b0, 4'd0, 32'd0, 32'd0);

    // store, W accepted before AW: IDLE 1 + D_WR 4 + D_WB 2
    set_delays(0, 0, 3, 0, 1);
    push_aw(32'h80001000, 32'hDEADBEEF, 4'b0011);
    push_done(32'h3C011234, 32'h0, 8'd8);
    do_req(1'b0, 32'd0, 1'b1, 4'b0011, 32'h80001000, 32'hDEADBEEF);

    // simultaneous load and fetch: data AR first
    set_delays(1, 1, 0, 0, 0);
    push_ar(4'd1, 32'h80002000);
    push_ar(4'd0, 32'hBFC00004);
    push_done(32'h22222222, 32'h11111111, 8'd10);
    do_req(1'b1, 32'hBFC00004, 1'b1, 4'd0, 32'h80002000, 32'd0);

    // back-to-back zero-wait fetches
    set_delays(0, 0, 0, 0, 0);
    push_ar(4'd0, 32'hBFC00000);
    push_done(32'h3C011234, 32'h11111111, 8'd4);
    do_req(1'b1, 32'hBFC00000, 1'b0, 4'd0, 32'd0, 32'd0);
    push_ar(4'd0, 32'hBFC00004);
    push_done(32'h22222222, 32'h11111111, 8'd4);
    do_req(1'b1, 32'hBFC00004, 1'b0, 4'd0, 32'd0, 32'd0);

    // data-only load; inst rdata must hold
    set_delays(1, 2, 0, 0, 0);
    push_ar(4'd1, 32'h80003000);
    push_done(32'h22222222, 32'hCAFEF00D, 8'd7);
    do_req(1'b0, 32'd0, 1'b1, 4'd0, 32'h80003000, 32'd0);

    // reset while in I_RD_D with the response still pending
    set_delays(0, 6, 0, 0, 0);
    push_ar(4'd0, 32'hBFC00000);
    inst_sram_en = 1'b1; inst_sram_addr = 32'hBFC00000;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #2;
      if (rready) break;
    end
    if (!rready) begin
      $display("FAIL reset_setup actual=rready low required=rready high");
      $fatal(1, "rready never rose");
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    inst_sram_en = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    set_delays(0, 0, 0, 0, 0);
    push_ar(4'd0, 32'hBFC00004);
    push_done(32'h22222222, 32'h0, 8'd4);
    do_req(1'b1, 32'hBFC00004, 1'b0, 4'd0, 32'd0, 32'd0);

    // store with pending fetch, AW before W: IDLE 1 + D_WR 3 + D_WB 1 + AR 1 + R 1
    set_delays(0, 0, 0, 2, 0);
    push_aw(32'h80004000, 32'h12345678, 4'b1111);
    push_ar(4'd0, 32'hBFC00000);
    push_done(32'h3C011234, 32'h0, 8'd8);
    do_req(1'b1, 32'hBFC00000, 1'b1, 4'b1111, 32'h80004000, 32'h12345678);

    repeat (3) @(posedge clk);
    #1 end_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #2;
      if (end_ack) break;
    end
    if (!end_ack) $display("FAIL end_handshake actual=no ack required=ack");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_axi_responder.md
Name: sram_axi_responder

Overview:
- Responder for the core's instruction and data SRAM-style ports (en/wen/addr/wdata to rdata), sitting between the 5-stage core and the AXI interconnect.
- Converts each SRAM-side access into a single-beat AXI3/4 transaction, one outstanding at a time.
- Raises stallreq to CTRL while any presented access is incomplete.
- Arbitrates the instruction and data ports; data has priority.

Parameters:
INST_ID, 4'd0, arid used for instruction fetches
DATA_ID, 4'd1, arid/awid used for data accesses

Ports:
clk  in  1  clock; all flops rising-edge
rst  in  1  asynchronous, active-low reset
inst_sram_en  in  1  instruction read request
inst_sram_addr  in  32  fetch address, word aligned
inst_sram_rdata  out  32  fetched word, registered
data_sram_en  in  1  data request
data_sram_wen  in  4  byte enables; 0 = read, nonzero = write
data_sram_addr  in  32  data address
data_sram_wdata  in  32  store data
data_sram_rdata  out  32  load data, registered
stallreq  out  1  freeze pipeline while access incomplete
arid/araddr/arvalid  out  4/32/1  AXI read address
arready  in  1
rdata/rvalid  in  32/1  AXI read data
rready  out  1
awid/awaddr/awvalid  out  4/32/1  AXI write address
awready  in  1
wdata/wstrb/wvalid  out  32/4/1  AXI write data
wready  in  1
bvalid  in  1
bready  out  1

Behaviour:
- Fixed AXI fields: arlen/awlen = 0, size = 3'b010, burst = INCR, wlast = wvalid. These fields are not ports.
- States: IDLE, D_RD_A, D_RD_D, D_WR, D_WB, I_RD_A, I_RD_D, DONE.
- IDLE:
  - data_sram_en=1 with wen=0 -> D_RD_A.
  - data_sram_en=1 with wen!=0 -> D_WR.
  - Else inst_sram_en=1 -> I_RD_A.
  - Else stay.
- Capture: request address, wdata and wen are registered on leaving IDLE. Inputs are don't-care afterwards. The core holds them stable anyway while stalled.
- *_RD_A:
  - arvalid=1, araddr = captured address, arid = DATA_ID or INST_ID.
  - arvalid stays high until arready; on arready go to *_RD_D.
- *_RD_D:
  - rready=1.
  - On rvalid, load rdata into the matching *_sram_rdata register.
  - Next state: D_RD_D goes to I_RD_A if the captured inst request is pending, else DONE. I_RD_D goes to DONE.
- D_WR:
  - awvalid and wvalid both asserted from entry; wstrb = captured wen.
  - Each valid drops individually after its own handshake.
  - Go to D_WB once both handshakes have completed, same cycle or different cycles in either order.
- D_WB: bready=1; on bvalid, go to I_RD_A if inst pending, else DONE. bresp is ignored.
- inst pending: inst_sram_en sampled in IDLE together with the data request (registered flag, address captured).
- DONE: lasts one cycle, then unconditionally back to IDLE.
- stallreq is combinational: (inst_sram_en | data_sram_en) & (state != DONE). It is 1 in IDLE when a request is presented, so the core never advances on a new access before it completes.
- Core side:
  - The core advances at the edge ending DONE and presents the next request in IDLE.
  - *_sram_rdata holds its value until overwritten by the next completed read on that port.
  - A port not serviced in a transaction keeps its old rdata.
- Only one AXI transaction is outstanding; AR and AW are never valid simultaneously.
- Reset (async, rst=0):
  - state = IDLE.
  - All valid/ready outputs 0; inst_sram_rdata = data_sram_rdata = 0; pending flag and captured registers 0.
  - Reset mid-transaction abandons it; the interconnect is reset together with the responder.
- arvalid/awvalid/wvalid/rready/bready are registered outputs or decoded from registered state only; none depends combinationally on AXI inputs.

Test Plan:
- Inst fetch only: inst_sram_en=1, addr=0xBFC00000; arready after 2 cycles, rvalid with 0x3C011234 after 3 more -> araddr=0xBFC00000, arid=0; stallreq=1 until DONE; inst_sram_rdata=0x3C011234; stallreq=0 exactly one cycle.
- Store: data_sram_en=1, wen=4'b0011, addr=0x80001000, wdata=0xDEADBEEF; wready 3 cycles before awready -> one W and one AW handshake, wstrb=0011; bready until bvalid; then DONE.
- Simultaneous load and fetch: data addr 0x80002000 returns 0x11111111, inst addr 0xBFC00004 returns 0x22222222 -> AR order data (id 1) then inst (id 0); both rdata registers updated; single DONE.
- Back-to-back fetches 0xBFC00000/04 with zero-wait AXI (arready=1, rvalid the cycle after AR) -> each fetch is IDLE, I_RD_A, I_RD_D, DONE; no duplicate AR for the same address.
- Reset asserted in I_RD_D with rvalid pending -> all AXI valids/readies 0 immediately; rdata registers 0; after release, IDLE and a new request starts cleanly.
- Load after fetch: rdata of the unserviced port is unchanged (inst_sram_rdata holds 0x22222222 across a data-only load).
